three_voter_sync: RTL and testbench

- Registered bitwise triple-modular-redundancy (TMR) majority voter.
- Combines three redundant copies of a WIDTH-bit signal into one voted output.
- Flags which lane disagreed with the vote and keeps per-lane saturating disagreement counters for health monitoring.
- Sits at the merge point of triplicated logic, feeding downstream single-string logic.

---
 rtl/three_voter_sync_if.sv | 48 ++++
 rtl/three_voter_sync.sv | 140 ++++++++++++++
 tb/tb_three_voter_sync.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/three_voter_sync_if.sv
// Lane inputs and voted/health outputs of the TMR voter; master drives lanes, slave is the voter.
// Fault flag signals exist only when THREE_VOTER_FAULT_LATCH_EN is defined.
interface three_voter_sync_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             clr_cnt;
    logic             out_valid;
    logic [WIDTH-1:0] y;
    logic             err_a;
    logic             err_b;
    logic             err_c;
    logic             all_agree;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic [CNT_W-1:0] cnt_c;
`ifdef THREE_VOTER_FAULT_LATCH_EN
    logic             fault_a;
    logic             fault_b;
    logic             fault_c;

    modport master (
        output in_valid, a, b, c, clr_cnt,
        input  out_valid, y, err_a, err_b, err_c, all_agree,
        input  cnt_a, cnt_b, cnt_c, fault_a, fault_b, fault_c
    );
    modport slave (
        input  in_valid, a, b, c, clr_cnt,
        output out_valid, y, err_a, err_b, err_c, all_agree,
        output cnt_a, cnt_b, cnt_c, fault_a, fault_b, fault_c
    );
`else
    modport master (
        output in_valid, a, b, c, clr_cnt,
        input  out_valid, y, err_a, err_b, err_c, all_agree,
        input  cnt_a, cnt_b, cnt_c
    );
    modport slave (
        input  in_valid, a, b, c, clr_cnt,
        output out_valid, y, err_a, err_b, err_c, all_agree,
        output cnt_a, cnt_b, cnt_c
    );
`endif
endinterface

// File: rtl/three_voter_sync.sv
// Registered bitwise 2-of-3 voter with per-lane disagreement flags and saturating counters; 1-cycle latency, no backpressure.
// THREE_VOTER_FAULT_LATCH_EN adds sticky per-lane fault flags and a degraded-mode output mux.
module three_voter_sync #(
    parameter int          WIDTH        = 1,
    parameter int          CNT_W        = 8,
    parameter int unsigned FAULT_THRESH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    three_voter_sync_if.slave bus
);
    logic [WIDTH-1:0] lane [3];
    logic [WIDTH-1:0] maj;
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_q;
    logic [2:0]       err_d;
    logic [2:0]       err_q;
    logic             agree_d;
    logic             agree_q;
    logic             vld_q;
    logic [CNT_W-1:0] cnt_d [3];
    logic [CNT_W-1:0] cnt_q [3];

    assign lane[0] = bus.a;
    assign lane[1] = bus.b;
    assign lane[2] = bus.c;

    assign maj     = (bus.a & bus.b) | (bus.a & bus.c) | (bus.b & bus.c);
    assign agree_d = (bus.a == bus.b) && (bus.b == bus.c);

`ifdef THREE_VOTER_FAULT_LATCH_EN
    logic [2:0] fault_d;
    logic [2:0] fault_q;

    // With exactly one lane condemned, trust only the AND of the two survivors.
    always_comb begin
        y_d = maj;
        for (int i = 0; i < 3; i++) begin
            err_d[i] = |(lane[i] ^ maj);
        end
        case (fault_q)
            3'b001: begin
                y_d      = lane[1] & lane[2];
                err_d[0] = |(lane[0] ^ y_d);
                err_d[1] = |(lane[1] ^ lane[2]);
                err_d[2] = |(lane[1] ^ lane[2]);
            end
            3'b010: begin
                y_d      = lane[0] & lane[2];
                err_d[1] = |(lane[1] ^ y_d);
                err_d[0] = |(lane[0] ^ lane[2]);
                err_d[2] = |(lane[0] ^ lane[2]);
            end
            3'b100: begin
                y_d      = lane[0] & lane[1];
                err_d[2] = |(lane[2] ^ y_d);
                err_d[0] = |(lane[0] ^ lane[1]);
                err_d[1] = |(lane[0] ^ lane[1]);
            end
            default: begin
                y_d = maj;
            end
        endcase
    end

    always_comb begin
        fault_d = fault_q;
        for (int i = 0; i < 3; i++) begin
            if (bus.clr_cnt) begin
                fault_d[i] = 1'b0;
            end else if (32'(cnt_q[i]) >= FAULT_THRESH) begin
                fault_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= '0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign bus.fault_a = fault_q[0];
    assign bus.fault_b = fault_q[1];
    assign bus.fault_c = fault_q[2];
`else
    always_comb begin
        y_d = maj;
        for (int i = 0; i < 3; i++) begin
            err_d[i] = |(lane[i] ^ maj);
        end
    end
`endif

    // Clear wins over an increment landing in the same cycle; counters stick at all-ones.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            if (bus.clr_cnt) begin
                cnt_d[i] = '0;
            end else if (bus.in_valid && err_d[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            y_q     <= '0;
            err_q   <= '0;
            agree_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            vld_q <= bus.in_valid;
            if (bus.in_valid) begin
                y_q     <= y_d;
                err_q   <= err_d;
                agree_q <= agree_d;
            end
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.y         = y_q;
    assign bus.err_a     = err_q[0];
    assign bus.err_b     = err_q[1];
    assign bus.err_c     = err_q[2];
    assign bus.all_agree = agree_q;
    assign bus.cnt_a     = cnt_q[0];
    assign bus.cnt_b     = cnt_q[1];
    assign bus.cnt_c     = cnt_q[2];
endmodule

// File: tb/tb_three_voter_sync.sv
// Bench for three_voter_sync: directed scenarios plus randomized traffic against an arithmetic reference model.
`timescale 1ns/1ps
module tb_three_voter_sync;
`ifdef THREE_VOTER_FAULT_LATCH_EN
    localparam int NK  = 3;
    localparam bit FEN = 1'b1;
`else
    localparam int NK  = 2;
    localparam bit FEN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #50 clk = ~clk;

    three_voter_sync_if #(.WIDTH(1), .CNT_W(2)) if1 ();
    three_voter_sync_if #(.WIDTH(4), .CNT_W(8)) if4 ();

    three_voter_sync #(.WIDTH(1), .CNT_W(2), .FAULT_THRESH(16)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    three_voter_sync #(.WIDTH(4), .CNT_W(8), .FAULT_THRESH(16)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    int drv_vld [3];
    int drv_a   [3];
    int drv_b   [3];
    int drv_c   [3];
    int drv_clr [3];

    logic [31:0] o_vld [NK];
    logic [31:0] o_y   [NK];
    logic [31:0] o_err [NK];
    logic [31:0] o_agr [NK];
    logic [31:0] o_cnt [NK][3];

    assign if1.in_valid = drv_vld[0][0];
    assign if1.a        = drv_a[0][0:0];
    assign if1.b        = drv_b[0][0:0];
    assign if1.c        = drv_c[0][0:0];
    assign if1.clr_cnt  = drv_clr[0][0];
    assign if4.in_valid = drv_vld[1][0];
    assign if4.a        = drv_a[1][3:0];
    assign if4.b        = drv_b[1][3:0];
    assign if4.c        = drv_c[1][3:0];
    assign if4.clr_cnt  = drv_clr[1][0];

    assign o_vld[0]    = {31'd0, if1.out_valid};
    assign o_y[0]      = {31'd0, if1.y};
    assign o_err[0]    = {29'd0, if1.err_c, if1.err_b, if1.err_a};
    assign o_agr[0]    = {31'd0, if1.all_agree};
    assign o_cnt[0][0] = {30'd0, if1.cnt_a};
    assign o_cnt[0][1] = {30'd0, if1.cnt_b};
    assign o_cnt[0][2] = {30'd0, if1.cnt_c};
    assign o_vld[1]    = {31'd0, if4.out_valid};
    assign o_y[1]      = {28'd0, if4.y};
    assign o_err[1]    = {29'd0, if4.err_c, if4.err_b, if4.err_a};
    assign o_agr[1]    = {31'd0, if4.all_agree};
    assign o_cnt[1][0] = {24'd0, if4.cnt_a};
    assign o_cnt[1][1] = {24'd0, if4.cnt_b};
    assign o_cnt[1][2] = {24'd0, if4.cnt_c};

`ifdef THREE_VOTER_FAULT_LATCH_EN
    three_voter_sync_if #(.WIDTH(1), .CNT_W(8)) iff ();
    three_voter_sync #(.WIDTH(1), .CNT_W(8), .FAULT_THRESH(2)) uf (.clk(clk), .rst_n(rst_n), .bus(iff));

    logic [31:0] o_flt [NK];
    assign iff.in_valid = drv_vld[2][0];
    assign iff.a        = drv_a[2][0:0];
    assign iff.b        = drv_b[2][0:0];
    assign iff.c        = drv_c[2][0:0];
    assign iff.clr_cnt  = drv_clr[2][0];
    assign o_vld[2]     = {31'd0, iff.out_valid};
    assign o_y[2]       = {31'd0, iff.y};
    assign o_err[2]     = {29'd0, iff.err_c, iff.err_b, iff.err_a};
    assign o_agr[2]     = {31'd0, iff.all_agree};
    assign o_cnt[2][0]  = {24'd0, iff.cnt_a};
    assign o_cnt[2][1]  = {24'd0, iff.cnt_b};
    assign o_cnt[2][2]  = {24'd0, iff.cnt_c};
    assign o_flt[0]     = {29'd0, if1.fault_c, if1.fault_b, if1.fault_a};
    assign o_flt[1]     = {29'd0, if4.fault_c, if4.fault_b, if4.fault_a};
    assign o_flt[2]     = {29'd0, iff.fault_c, iff.fault_b, iff.fault_a};
`endif

    // Reference model state per instance
    int p_w   [3] = '{1, 4, 1};
    int p_max [3] = '{3, 255, 255};
    int p_th  [3] = '{16, 16, 2};
    int m_vld [NK];
    int m_y   [NK];
    int m_err [NK];
    int m_agr [NK];
    int m_cnt [NK][3];
    int m_flt [NK][3];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NK; k++) begin
            m_vld[k] = 0; m_y[k] = 0; m_err[k] = 0; m_agr[k] = 0;
            for (int i = 0; i < 3; i++) begin
                m_cnt[k][i] = 0; m_flt[k][i] = 0;
            end
        end
    endtask

    task automatic model_step(input int k);
        int ln [3];
        int e  [3];
        int fl [3];
        int v, yv, nf, h0, hd;
        bit have_h;
        ln[0] = drv_a[k]; ln[1] = drv_b[k]; ln[2] = drv_c[k];
        v = 0;
        for (int i = 0; i < p_w[k]; i++)
            if (((ln[0] >> i) & 1) + ((ln[1] >> i) & 1) + ((ln[2] >> i) & 1) >= 2) v |= (1 << i);
        nf = FEN ? (m_flt[k][0] + m_flt[k][1] + m_flt[k][2]) : 0;
        yv = v;
        for (int i = 0; i < 3; i++) e[i] = (ln[i] != v) ? 1 : 0;
        if (nf == 1) begin
            yv = (1 << p_w[k]) - 1;
            have_h = 1'b0; h0 = 0; hd = 0;
            for (int i = 0; i < 3; i++) begin
                if (m_flt[k][i] == 0) begin
                    yv &= ln[i];
                    if (!have_h) begin h0 = ln[i]; have_h = 1'b1; end
                    else hd = (ln[i] != h0) ? 1 : 0;
                end
            end
            for (int i = 0; i < 3; i++) e[i] = (m_flt[k][i] != 0) ? ((ln[i] != yv) ? 1 : 0) : hd;
        end
        for (int i = 0; i < 3; i++) begin
            if (!FEN || drv_clr[k] != 0) fl[i] = 0;
            else fl[i] = (m_flt[k][i] != 0 || m_cnt[k][i] >= p_th[k]) ? 1 : 0;
        end
        if (drv_vld[k] != 0) begin
            m_y[k]   = yv;
            m_err[k] = e[0] | (e[1] << 1) | (e[2] << 2);
            m_agr[k] = (ln[0] == ln[1] && ln[1] == ln[2]) ? 1 : 0;
            for (int i = 0; i < 3; i++)
                if (e[i] != 0 && m_cnt[k][i] < p_max[k]) m_cnt[k][i]++;
        end
        if (drv_clr[k] != 0)
            for (int i = 0; i < 3; i++) m_cnt[k][i] = 0;
        m_vld[k] = drv_vld[k];
        for (int i = 0; i < 3; i++) m_flt[k][i] = fl[i];
    endtask

    task automatic check_all(input int k);
        chk($sformatf("k%0d out_valid", k), o_vld[k], m_vld[k]);
        chk($sformatf("k%0d y", k), o_y[k], m_y[k]);
        chk($sformatf("k%0d err", k), o_err[k], m_err[k]);
        chk($sformatf("k%0d all_agree", k), o_agr[k], m_agr[k]);
        for (int i = 0; i < 3; i++)
            chk($sformatf("k%0d cnt%0d", k, i), o_cnt[k][i], m_cnt[k][i]);
`ifdef THREE_VOTER_FAULT_LATCH_EN
        chk($sformatf("k%0d fault", k), o_flt[k], m_flt[k][0] | (m_flt[k][1] << 1) | (m_flt[k][2] << 2));
`endif
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            drv_vld[k] = 0; drv_a[k] = 0; drv_b[k] = 0; drv_c[k] = 0; drv_clr[k] = 0;
        end
    endtask

    task automatic drive(input int k, input int v, input int a, input int b, input int c, input int clr);
        drv_vld[k] = v; drv_a[k] = a; drv_b[k] = b; drv_c[k] = c; drv_clr[k] = clr;
    endtask

    // One clock: sample 1 ns after the edge, advance the model, compare every instance
    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < NK; k++) model_step(k);
        for (int k = 0; k < NK; k++) check_all(k);
    endtask

    int tt_y   [8] = '{0, 0, 0, 1, 0, 1, 1, 1};
    int tt_err [8] = '{0, 4, 2, 1, 1, 2, 4, 0};
    int tt_agr [8] = '{1, 0, 0, 0, 0, 0, 0, 1};
    int sat_exp [5] = '{1, 2, 3, 3, 3};
    int saved_cnt [3];

    initial begin
        idle_all();
        model_reset();
        #20;
        for (int k = 0; k < NK; k++) check_all(k);
        @(negedge clk);
        rst_n = 1'b1;

        // Truth table on the 1-bit instance
        for (int t = 0; t < 8; t++) begin
            drive(0, 1, (t >> 2) & 1, (t >> 1) & 1, t & 1, 0);
            tick();
            chk($sformatf("tt%0d y", t), o_y[0], tt_y[t]);
            chk($sformatf("tt%0d err", t), o_err[0], tt_err[t]);
            chk($sformatf("tt%0d all_agree", t), o_agr[0], tt_agr[t]);
        end

        // Asynchronous reset between edges
        drive(0, 1, 1, 0, 0, 0);
        tick();
        #20;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", if1.out_valid, 0);
        chk("async rst y", if1.y, 0);
        chk("async rst cnt_a", if1.cnt_a, 0);
        model_reset();
        for (int k = 0; k < NK; k++) check_all(k);
        idle_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation of a 2-bit counter, then clear racing an increment
        drive(0, 0, 0, 0, 0, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 1, 0, 0, 0);
            tick();
            chk($sformatf("sat cnt_a step%0d", i), o_cnt[0][0], sat_exp[i]);
        end
        drive(0, 1, 1, 0, 0, 1);
        tick();
        chk("clr vs inc cnt_a", o_cnt[0][0], 0);
        chk("clr keeps err_a", o_err[0], 1);

        // Valid gating: outputs hold while idle
        drive(0, 1, 1, 1, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) saved_cnt[i] = m_cnt[0][i];
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            tick();
            chk($sformatf("gate%0d out_valid", i), o_vld[0], 0);
            chk($sformatf("gate%0d y", i), o_y[0], 1);
            chk($sformatf("gate%0d cnt_c", i), o_cnt[0][2], saved_cnt[2]);
        end

        // Multi-bit: every lane wrong in a different bit
        drive(1, 1, 4'hF, 4'h3, 4'h5, 0);
        tick();
        chk("mb y", o_y[1], 4'h7);
        chk("mb err", o_err[1], 3'b111);
        chk("mb all_agree", o_agr[1], 0);
        idle_all();

`ifdef THREE_VOTER_FAULT_LATCH_EN
        drive(2, 0, 0, 0, 0, 1);
        tick();
        drive(2, 1, 0, 0, 1, 0);
        tick();
        tick();
        drive(2, 0, 0, 0, 0, 0);
        tick();
        chk("fault_c set", o_flt[2], 3'b100);
        drive(2, 1, 1, 0, 1, 0);
        tick();
        chk("degraded y", o_y[2], 0);
        chk("degraded err_a/err_b", o_err[2] & 3'b011, 3'b011);
        idle_all();
`endif

        // Randomized traffic on all instances
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NK; k++) begin
                drive(k, ($urandom_range(0, 3) != 0) ? 1 : 0,
                      int'($urandom_range(0, (1 << p_w[k]) - 1)),
                      int'($urandom_range(0, (1 << p_w[k]) - 1)),
                      int'($urandom_range(0, (1 << p_w[k]) - 1)),
                      ($urandom_range(0, 15) == 0) ? 1 : 0);
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
